bram_dp_init: RTL and testbench
===============================

Name: bram_dp_init

Overview:
Parametrised simple-dual-port block RAM: one write port and one registered read port, inferred as iCE40 BRAM. Successor to the fixed 8x256 memory. Adds:
- hardware clear of every location to a programmable value after reset
- a ready flag
- read-valid tracking
- selectable read-during-write behaviour
- an optional output pipeline register
Used as the generic buffer or lookup store behind UART, FIFO and display blocks.

Parameters:
DATA_WIDTH, 8, width of a stored word in bits.
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words.
INIT_VALUE, 0, word written to every location during the post-reset clear.
BYPASS, 1, same-address read-during-write: 1 = return new write data, 0 = return old contents.
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
w_en  input  1  write enable; ignored while ready=0.
w_addr  input  ADDR_WIDTH  write address.
w_data  input  DATA_WIDTH  write data.
r_en  input  1  read enable; ignored while ready=0.
r_addr  input  ADDR_WIDTH  read address.
r_data  output  DATA_WIDTH  read data; holds its last value between reads.
r_valid  output  1  one-cycle pulse, aligned with fresh r_data.
collision  output  1  one-cycle pulse aligned with r_valid; set when that read hit the address being written in the same cycle.
ready  output  1  high once the clear has completed; port accesses are accepted only while ready=1.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: r_data=0, r_valid=0, collision=0, ready=0, state=CLEAR, clear counter=0, OUT_REG stage registers=0. The memory array itself is never reset; the clear is the only initialisation.

FSM states: CLEAR and RUN.
- CLEAR:
  - Each edge with rst=0 writes INIT_VALUE to mem[cnt] and increments cnt.
  - On the edge that writes DEPTH-1, go to RUN and set ready=1.
  - So ready rises on the DEPTH-th rising edge after rst falls (edge 256 for defaults).
  - User w_en and r_en are ignored; r_valid stays 0.
- RUN:
  - ready stays 1 until the next rst.
  - No path leads back to CLEAR except rst.

Write:
- An edge with ready=1 and w_en=1 stores w_data at w_addr.
- Latency 0: a read issued on the following edge sees the new data.

Read:
- An edge with ready=1 and r_en=1 samples r_addr.
- OUT_REG=0: r_data is updated and r_valid=1 after that same edge, for 1 cycle.
- OUT_REG=1: both appear one edge later.
- Back-to-back reads give one r_valid per cycle.
- r_en=0: r_valid=0 and r_data is held.

Simultaneous read and write:
- Different addresses: independent; read returns old contents.
- Same address, BYPASS=1: r_data = w_data of that cycle; collision=1.
- Same address, BYPASS=0: r_data = previous contents; collision=1.
- collision is 0 on every cycle where r_valid=0.

Boundaries:
- Address DEPTH-1 must be writable and readable; no wrap logic is needed.
- Writes and reads issued in the cycle ready rises are accepted.

Reset mid-operation:
- rst in RUN or CLEAR returns the block to CLEAR with cnt=0 and ready=0.
- In-flight reads, including the OUT_REG stage, are dropped: no r_valid after rst.
- All contents are re-cleared.
- rst held high keeps the block in reset; the clear starts on the first edge after rst falls.

Arithmetic:
- cnt is ADDR_WIDTH+1 bits, or compares to DEPTH-1 with no overflow.
- Address comparison is full-width equality.

Test Plan:
1. Defaults, rst for 2 cycles then low -> ready=0 for 255 edges, ready=1 after edge 256; no r_valid during clear; reads of 0x00, 0x80, 0xFF return 0x00.
2. INIT_VALUE=8'hA5, DATA_WIDTH=8 -> after ready, reads of all 256 addresses return 0xA5; accesses during clear (w_en=1, w_addr=0x01, w_data=0xFF) are ignored and 0x01 still reads 0xA5.
3. Write 0x01<-0xFF, next cycle read 0x01 -> with OUT_REG=0, r_data=0xFF and r_valid=1 one cycle after the read edge; with OUT_REG=1, two cycles after.
4. Same-cycle write 0x10<-0x3C and read 0x10 (old value 0x00) -> BYPASS=1: r_data=0x3C and collision=1; BYPASS=0: r_data=0x00 and collision=1; a different-address pair gives collision=0.
5. Write 0xFF<-0x5A then read 0xFF -> 0x5A; DATA_WIDTH=16, ADDR_WIDTH=9: write 511<-16'hBEEF and read it back -> 16'hBEEF, and ready rises on edge 512.
6. rst pulsed during a read burst in RUN (after writing 0x01<-0xFF) -> r_valid=0 from the next edge, ready=0, no late r_valid from the OUT_REG stage; after re-clear, 0x01 reads INIT_VALUE.

Source files
------------

// File: rtl/bram_dp_init.sv
// Simple-dual-port block RAM with post-reset clear to INIT_VALUE, a ready flag,
// read-valid/collision tracking, selectable read-during-write and optional output register.
module bram_dp_init #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit                    BYPASS     = 1'b1,
  parameter bit                    OUT_REG    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  collision,
  output logic                  ready
);

  // state | meaning
  // CLEAR | writing INIT_VALUE to mem[cnt]; user ports ignored
  // RUN   | normal operation; ready=1 until rst
  typedef enum logic {CLEAR, RUN} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic                  s1_coll;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  hit;

  assign acc_rd  = (state == RUN) && r_en;
  assign acc_wr  = (state == RUN) && w_en;
  assign hit     = acc_wr && (w_addr == r_addr);
  assign rd_word = (BYPASS && hit) ? w_data : mem[r_addr];

  // Array has no reset so it maps onto block RAM; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[cnt] <= INIT_VALUE;
      else if (w_en)      mem[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      ready     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      collision <= 1'b0;
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      s1_coll   <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          state <= RUN;
          ready <= 1'b1;
        end
      end

      if (OUT_REG) begin
        s1_valid  <= acc_rd;
        s1_coll   <= acc_rd && hit;
        if (acc_rd)   s1_data <= rd_word;
        if (s1_valid) r_data  <= s1_data;
        r_valid   <= s1_valid;
        collision <= s1_coll;
      end else begin
        if (acc_rd) r_data <= rd_word;
        r_valid   <= acc_rd;
        collision <= acc_rd && hit;
      end
    end
  end

endmodule

// File: tb/tb_bram_dp_init.sv
// Scoreboard bench: two bram_dp_init configurations share one stimulus stream and are
// compared against an array-based reference model with per-read expected-arrival cycles.
module tb_bram_dp_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, w_en, r_en;
  logic [8:0]  w_addr, r_addr;
  logic [15:0] w_data;

  logic [7:0]  a_rdata;
  logic        a_rvalid, a_coll, a_ready;
  logic [15:0] b_rdata;
  logic        b_rvalid, b_coll, b_ready;

  bram_dp_init #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .INIT_VALUE(8'hA5),
                 .BYPASS(1'b1), .OUT_REG(1'b0)) dut_a (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr[7:0]), .w_data(w_data[7:0]),
    .r_en(r_en), .r_addr(r_addr[7:0]), .r_data(a_rdata), .r_valid(a_rvalid),
    .collision(a_coll), .ready(a_ready));

  bram_dp_init #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .INIT_VALUE(16'h0000),
                 .BYPASS(1'b0), .OUT_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr), .r_data(b_rdata), .r_valid(b_rvalid),
    .collision(b_coll), .ready(b_ready));

  typedef struct {
    logic [15:0] data;
    logic        coll;
    int          due;
    int          ep;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          depth [2] = '{256, 512};
  logic [15:0] initv [2] = '{16'h00A5, 16'h0000};
  logic [15:0] dmask [2] = '{16'h00FF, 16'hFFFF};
  bit          byp   [2] = '{1'b1, 1'b0};
  int          lat   [2] = '{0, 1};

  logic [15:0] mem_m [2][512];
  int          clr_cnt [2] = '{0, 0};
  bit          mdl_rdy [2] = '{1'b0, 1'b0};
  int          epoch   [2] = '{0, 0};
  int          cyc = 0;

  int          seen_ep [2] = '{0, 0};
  logic [15:0] last    [2] = '{16'h0, 16'h0};
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model: clear takes DEPTH edges, then reads return memory (or bypass) contents
  always @(posedge clk) begin
    int   wa, ra;
    logic [15:0] wd;
    exp_t e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        clr_cnt[k] = 0;
        mdl_rdy[k] = 1'b0;
        epoch[k]++;
      end else if (!mdl_rdy[k]) begin
        clr_cnt[k]++;
        if (clr_cnt[k] == depth[k]) begin
          for (int i = 0; i < depth[k]; i++) mem_m[k][i] = initv[k];
          mdl_rdy[k] = 1'b1;
        end
      end else begin
        wa = int'(w_addr) % depth[k];
        ra = int'(r_addr) % depth[k];
        wd = w_data & dmask[k];
        if (r_en) begin
          e.coll = w_en && (wa == ra);
          e.data = (e.coll && byp[k]) ? wd : mem_m[k][ra];
          e.due  = cyc + lat[k];
          e.ep   = epoch[k];
          if (k == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
        if (w_en) mem_m[k][wa] = wd;
      end
    end
  end

  task automatic check(int k, string nm, logic [15:0] act, logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL dut%0d %s: actual %h required %h at cycle %0d", k, nm, act, req, cyc);
    end
  endtask

  task automatic mon(int k, logic [15:0] d, logic v, logic c, logic rdy);
    exp_t e;
    bit   due_now = 1'b0;
    if (epoch[k] != seen_ep[k]) begin
      seen_ep[k] = epoch[k];
      last[k]    = '0;
    end
    if (k == 0) begin
      while (q0.size() > 0 && q0[0].ep != epoch[0]) void'(q0.pop_front());
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); due_now = 1'b1; end
    end else begin
      while (q1.size() > 0 && q1[0].ep != epoch[1]) void'(q1.pop_front());
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); due_now = 1'b1; end
    end
    check(k, "ready", 16'(rdy), 16'(mdl_rdy[k]));
    if (due_now) begin
      check(k, "r_valid", 16'(v), 16'd1);
      check(k, "collision", 16'(c), 16'(e.coll));
      last[k] = e.data;
    end else begin
      check(k, "r_valid", 16'(v), 16'd0);
      check(k, "collision", 16'(c), 16'd0);
    end
    check(k, "r_data", d, last[k]);
  endtask

  always @(negedge clk) begin
    mon(0, {8'h00, a_rdata}, a_rvalid, a_coll, a_ready);
    mon(1, b_rdata, b_rvalid, b_coll, b_ready);
  end

  task automatic drive(bit we, int wa, int wd, bit re, int ra);
    w_en   = we;
    w_addr = wa[8:0];
    w_data = wd[15:0];
    r_en   = re;
    r_addr = ra[8:0];
    @(negedge clk);
  endtask

  // Hammers the ports early in the clear, then issues a colliding access the cycle dut_a turns ready.
  task automatic clear_phase();
    bit a_seen = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      w_en = 1'b0;
      r_en = 1'b0;
      if (n < 250) begin
        w_en = 1'b1; w_addr = 9'h001; w_data = 16'hFFFF;
        r_en = 1'b1; r_addr = 9'h001;
      end
      if (a_ready && !a_seen) begin
        a_seen = 1'b1;
        w_en = 1'b1; w_addr = 9'h003; w_data = 16'h0077;
        r_en = 1'b1; r_addr = 9'h003;
      end
      @(negedge clk);
      if (a_ready && b_ready && a_seen) begin
        w_en = 1'b0;
        r_en = 1'b0;
        return;
      end
    end
    $display("FAIL ready_timeout: actual a=%0d b=%0d required 1 1", a_ready, b_ready);
    $fatal(1, "ready never rose");
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; w_addr = '0; r_addr = '0; w_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_phase();

    for (int i = 0; i < 512; i++) drive(1'b0, 0, 0, 1'b1, i);

    drive(1'b1, 9'h001, 16'h00FF, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b1, 9'h001);
    drive(1'b1, 9'h010, 16'h003C, 1'b1, 9'h010);
    drive(1'b1, 9'h014, 16'h1111, 1'b1, 9'h015);
    drive(1'b1, 9'h0FF, 16'h005A, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b1, 9'h0FF);
    drive(1'b1, 9'h1FF, 16'hBEEF, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b1, 9'h1FF);
    drive(1'b0, 0, 0, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b0, 0);

    for (int i = 0; i < 2000; i++) begin
      int wa, ra;
      wa = (($urandom & 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 7));
      ra = (($urandom & 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 7));
      drive(1'($urandom), wa, int'($urandom), 1'($urandom), ra);
    end

    drive(1'b1, 9'h001, 16'h00FF, 1'b0, 0);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 1'b1, i);
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b1, 9'h001);
    rst = 1'b0;
    clear_phase();
    drive(1'b0, 0, 0, 1'b1, 9'h001);
    drive(1'b0, 0, 0, 1'b1, 9'h1FF);
    repeat (4) drive(1'b0, 0, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
